// File: rtl/irq_scheduler.sv
// Single-level interrupt scheduler: latches request pulses, picks the lowest-index
// eligible source, and walks one trap through issue, start, done and service.
module irq_scheduler #(
  parameter int START_TIMEOUT = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rdy_in,
  input  logic [7:0] irq_src,
  input  logic [7:0] irq_mask,
  input  logic       global_enable,
  input  logic       trap_busy,
  input  logic       mret_in,
  output logic       interrupt_enable,
  output logic [2:0] interrupt_cause,
  output logic [7:0] pending_out,
  output logic       in_service
);

  localparam int CntW = (START_TIMEOUT < 2) ? 1 : $clog2(START_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE,
    SERVICE
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       pending_q, pending_d;
  logic [2:0]       cause_q, cause_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [7:0]       eligible;
  logic [2:0]       pickIdx;
  logic             anyEligible;

  // Lowest index wins, so scan downward and let the last hit stick.
  always_comb begin
    eligible = pending_q & irq_mask & {8{global_enable}};
    pickIdx  = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (eligible[i]) pickIdx = 3'(i);
    end
    anyEligible = |eligible;
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cause_d   = cause_q;
    cnt_d     = cnt_q;

    if (rdy_in) begin
      unique case (state_q)
        IDLE: begin
          if (anyEligible) begin
            cause_d            = pickIdx;
            pending_d[pickIdx] = 1'b0;
            state_d            = ISSUE;
          end
        end
        ISSUE: begin
          cnt_d   = CntW'(START_TIMEOUT);
          state_d = WAIT_START;
        end
        WAIT_START: begin
          if (trap_busy) begin
            state_d = WAIT_DONE;
          end else if (cnt_q <= CntW'(1)) begin
            // Sequencer never picked the trap up: give the source back.
            pending_d[cause_q] = 1'b1;
            cnt_d              = '0;
            state_d            = IDLE;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        WAIT_DONE: begin
          if (!trap_busy) state_d = SERVICE;
        end
        SERVICE: begin
          if (mret_in) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // New requests are applied last so a same-cycle set beats an issue clear.
    pending_d = pending_d | irq_src;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      pending_q <= '0;
      cause_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cause_q   <= cause_d;
      cnt_q     <= cnt_d;
    end
  end

  assign interrupt_enable = (state_q == ISSUE);
  assign in_service       = (state_q != IDLE);
  assign interrupt_cause  = cause_q;
  assign pending_out      = pending_q;

endmodule

// File: tb/tb_irq_scheduler.sv
// Bench for irq_scheduler: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model of one trap in flight.
module tb_irq_scheduler;

  localparam int START_TIMEOUT = 4;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       rdy_in;
  logic [7:0] irq_src;
  logic [7:0] irq_mask;
  logic       global_enable;
  logic       trap_busy;
  logic       mret_in;
  logic       interrupt_enable;
  logic [2:0] interrupt_cause;
  logic [7:0] pending_out;
  logic       in_service;

  int assertCount = 0;
  int failCount   = 0;
  int cycleNum    = 0;

  irq_scheduler #(.START_TIMEOUT(START_TIMEOUT)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .irq_src          (irq_src),
    .irq_mask         (irq_mask),
    .global_enable    (global_enable),
    .trap_busy        (trap_busy),
    .mret_in          (mret_in),
    .interrupt_enable (interrupt_enable),
    .interrupt_cause  (interrupt_cause),
    .pending_out      (pending_out),
    .in_service       (in_service)
  );

  always #5 clk_in = ~clk_in;

  // Model view: at most one trap is active; stage 0 = being offered, 1 = waiting for the
  // sequencer to start, 2 = sequencer running, 3 = handler running until mret.
  logic [7:0] mPend   = 8'h00;
  logic       mActive = 1'b0;
  int         mStage  = 0;
  logic [2:0] mCause  = 3'd0;
  int         mWaited = 0;

  function automatic logic [2:0] lowestSet(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      if (v[i]) return 3'(i);
    end
    return 3'd0;
  endfunction

  always @(posedge clk_in or posedge rst_in) begin : refModel
    logic [7:0] p;
    logic [7:0] elig;
    logic       act;
    int         stg;
    logic [2:0] c;
    int         w;
    if (rst_in) begin
      mPend   <= 8'h00;
      mActive <= 1'b0;
      mStage  <= 0;
      mCause  <= 3'd0;
      mWaited <= 0;
    end else begin
      p   = mPend;
      act = mActive;
      stg = mStage;
      c   = mCause;
      w   = mWaited;
      if (rdy_in) begin
        if (!act) begin
          elig = global_enable ? (p & irq_mask) : 8'h00;
          if (elig != 8'h00) begin
            c    = lowestSet(elig);
            p[c] = 1'b0;
            act  = 1'b1;
            stg  = 0;
          end
        end else begin
          case (stg)
            0: begin stg = 1; w = 0; end
            1: begin
              if (trap_busy) stg = 2;
              else begin
                w = w + 1;
                if (w >= START_TIMEOUT) begin
                  p[c] = 1'b1;
                  act  = 1'b0;
                end
              end
            end
            2: if (!trap_busy) stg = 3;
            default: if (mret_in) act = 1'b0;
          endcase
        end
      end
      p = p | irq_src;
      mPend   <= p;
      mActive <= act;
      mStage  <= stg;
      mCause  <= c;
      mWaited <= w;
    end
  end

  always @(negedge clk_in) begin
    cycleNum++;
    if (!rst_in) begin
      assertCount++;
      if (interrupt_enable !== (mActive && mStage == 0) || in_service !== mActive ||
          interrupt_cause !== mCause || pending_out !== mPend) begin
        failCount++;
        $display("[TB] FAIL model cycle %0d: got ie=%0b cause=%0d pend=%h svc=%0b, expected ie=%0b cause=%0d pend=%h svc=%0b",
                 cycleNum, interrupt_enable, interrupt_cause, pending_out, in_service,
                 (mActive && mStage == 0), mCause, mPend, mActive);
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] src, input logic busy, input logic mret);
    irq_src   = src;
    trap_busy = busy;
    mret_in   = mret;
    @(posedge clk_in);
    #2;
  endtask

  task automatic checkOutput(input string name, input logic ie, input logic [2:0] cause,
                             input logic [7:0] pend, input logic svc);
    assertCount++;
    if (interrupt_enable !== ie || interrupt_cause !== cause || pending_out !== pend ||
        in_service !== svc) begin
      failCount++;
      $display("[TB] FAIL %s: got ie=%0b cause=%0d pend=%h svc=%0b, expected ie=%0b cause=%0d pend=%h svc=%0b",
               name, interrupt_enable, interrupt_cause, pending_out, in_service, ie, cause, pend, svc);
    end
  endtask

  task automatic finishTrap();
    applyStimulus(8'h00, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; irq_src = 8'h00; irq_mask = 8'hFF;
    global_enable = 1'b1; trap_busy = 1'b0; mret_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #2 rst_in = 1'b0;
    checkOutput("reset_state", 1'b0, 3'd0, 8'h00, 1'b0);

    $display("[TB] single source");
    applyStimulus(8'h04, 1'b0, 1'b0);
    checkOutput("single_pend", 1'b0, 3'd0, 8'h04, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("single_issue", 1'b1, 3'd2, 8'h00, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("single_ie_drop", 1'b0, 3'd2, 8'h00, 1'b1);
    finishTrap();
    checkOutput("single_mret", 1'b0, 3'd2, 8'h00, 1'b0);

    $display("[TB] priority and masking");
    irq_mask = 8'hFE;
    applyStimulus(8'h29, 1'b0, 1'b0);
    checkOutput("prio_pend", 1'b0, 3'd2, 8'h29, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("prio_first", 1'b1, 3'd3, 8'h21, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b0);
    finishTrap();
    checkOutput("prio_mret1", 1'b0, 3'd3, 8'h21, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("prio_second", 1'b1, 3'd5, 8'h01, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b0);
    finishTrap();
    checkOutput("prio_masked_stays", 1'b0, 3'd5, 8'h01, 1'b0);
    irq_mask = 8'hFF;
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("prio_unmasked", 1'b1, 3'd0, 8'h00, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b0);
    finishTrap();

    $display("[TB] start timeout");
    applyStimulus(8'h10, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("abort_issue", 1'b1, 3'd4, 8'h00, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b0);
    repeat (3) applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("abort_still_waiting", 1'b0, 3'd4, 8'h00, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("abort_restored", 1'b0, 3'd4, 8'h10, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("abort_reissue", 1'b1, 3'd4, 8'h00, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b0);
    finishTrap();

    $display("[TB] ready stall");
    applyStimulus(8'h02, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'h00, 1'b0, 1'b0);
      checkOutput("stall_hold", 1'b1, 3'd1, 8'h00, 1'b1);
    end
    rdy_in = 1'b1;
    checkOutput("stall_last_cycle", 1'b1, 3'd1, 8'h00, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("stall_released", 1'b0, 3'd1, 8'h00, 1'b1);
    finishTrap();

    $display("[TB] set beats clear, then async reset");
    applyStimulus(8'h02, 1'b0, 1'b0);
    applyStimulus(8'h02, 1'b0, 1'b0);
    checkOutput("set_wins", 1'b1, 3'd1, 8'h02, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0);
    #1 rst_in = 1'b1;
    #1 checkOutput("async_reset", 1'b0, 3'd0, 8'h00, 1'b0);
    @(posedge clk_in);
    #2 rst_in = 1'b0;
    trap_busy = 1'b0;
    checkOutput("reset_no_repend", 1'b0, 3'd0, 8'h00, 1'b0);
    applyStimulus(8'h01, 1'b0, 1'b0);
    checkOutput("post_reset_edge1", 1'b0, 3'd0, 8'h01, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("post_reset_edge2", 1'b1, 3'd0, 8'h00, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b0);
    finishTrap();

    $display("[TB] random traffic");
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) irq_mask = 8'($urandom);
      global_enable = ($urandom_range(0, 9) != 0);
      rdy_in        = ($urandom_range(0, 4) != 0);
      rst_in        = ($urandom_range(0, 299) == 0);
      applyStimulus(($urandom_range(0, 3) == 0) ? 8'($urandom & $urandom) : 8'h00,
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
    end
    rst_in = 1'b0;
    applyStimulus(8'h00, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/irq_scheduler.md
IRQ_SCHEDULER -- requirements
Module: irq_scheduler

Interface
REQ-001 SHALL have parameter START_TIMEOUT, default 4, meaning the maximum number of rdy_in-qualified cycles to wait for trap_busy after an issue.
REQ-002 SHALL have port clk_in  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst_in  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port rdy_in  input  1  global ready; the FSM advances only when high.
REQ-005 SHALL have port irq_src  input  8  per-source request pulses; bit i high for one cycle raises source i.
REQ-006 SHALL have port irq_mask  input  8  per-source enable (mie image); 1 = enabled.
REQ-007 SHALL have port global_enable  input  1  machine interrupt enable (mstatus.MIE image).
REQ-008 SHALL have port trap_busy  input  1  stall output of the trap sequencer; high while it is redirecting the PC.
REQ-009 SHALL have port mret_in  input  1  one-cycle pulse when an mret retires.
REQ-010 SHALL have port interrupt_enable  output  1  trap request to the trap sequencer.
REQ-011 SHALL have port interrupt_cause  output  3  index of the source being issued or serviced.
REQ-012 SHALL have port pending_out  output  8  current pending register.
REQ-013 SHALL have port in_service  output  1  high from issue until mret or abort.

Function
REQ-014 SHALL hold an 8-bit pending register; bit i SHALL set on irq_src[i]==1 regardless of rdy_in or FSM state.
REQ-015 SHALL treat a source as eligible when pending[i] & irq_mask[i] are both 1 and global_enable==1.
REQ-016 SHALL select the lowest-index eligible source (bit 0 highest priority).
REQ-017 SHALL implement states IDLE, ISSUE, WAIT_START, WAIT_DONE and SERVICE; all transitions SHALL be gated by rdy_in==1.
REQ-018 IDLE: if any source is eligible, SHALL latch its index into interrupt_cause, clear its pending bit, and go to ISSUE next cycle.
REQ-019 ISSUE: SHALL drive interrupt_enable=1 for exactly one rdy_in-qualified cycle, load the timeout counter with START_TIMEOUT, and then go to WAIT_START.
REQ-020 WAIT_START: on trap_busy==1, SHALL go to WAIT_DONE.
REQ-021 WAIT_START: otherwise SHALL decrement the counter; on expiry at 0, SHALL re-set pending[interrupt_cause], clear in_service, and go to IDLE (abort).
REQ-022 WAIT_DONE: on trap_busy==0, SHALL go to SERVICE.
REQ-023 SERVICE: on mret_in==1, SHALL clear in_service and go to IDLE; no new issue before the cycle after that transition.
REQ-024 SHALL NOT nest: while not in IDLE, new requests only accumulate in the pending register.
REQ-025 in_service SHALL be 1 in ISSUE, WAIT_START, WAIT_DONE and SERVICE, and 0 in IDLE.
REQ-026 While rdy_in==0, SHALL hold the state, the counter and all outputs, including interrupt_enable if it is already high.
REQ-027 If irq_src[i] is set in the same cycle that pending[i] is cleared by an issue, set SHALL win and pending[i] SHALL remain 1.
REQ-028 mret_in outside SERVICE SHALL be ignored.
REQ-029 Changes to irq_mask or global_enable after ISSUE SHALL NOT cancel an in-flight trap.
REQ-030 pending_out SHALL reflect the register value after the current edge, with no extra delay.

Reset
REQ-031 On rst_in==1, asynchronously and without waiting for a clock edge, the block SHALL enter IDLE and clear pending, the counter, interrupt_enable, interrupt_cause and in_service to 0.
REQ-032 Reset asserted mid-service SHALL discard the in-flight source; it SHALL NOT be re-pended.
REQ-033 After rst_in falls, the first issue SHALL occur no earlier than the second rising edge.

Verification
REQ-034 Single source: pulse irq_src=8'h04 with mask=8'hFF and global_enable=1 -> interrupt_enable is high for 1 cycle with cause=2, and pending_out returns to 8'h00.
REQ-035 Priority and masking: pulse irq_src=8'h29 with mask=8'hFE -> cause=3 is issued first; after the trap completes (trap_busy 1 then 0) and mret, cause=5 is issued; bit 0 stays pending.
REQ-036 Abort: issue, then hold trap_busy=0 for 4 cycles -> the FSM returns to IDLE, the pending bit is restored, and interrupt_enable re-pulses on the next eligible cycle.
REQ-037 rdy_in stall: drop rdy_in during ISSUE for 3 cycles -> interrupt_enable stays high and the state is unchanged; after rdy_in rises it is high for exactly one more cycle.
REQ-038 Simultaneous set and clear, plus async reset: re-pulse source 1 in its issue cycle -> pending[1] stays 1; then assert rst_in mid-WAIT_DONE between clock edges -> all outputs are 0 immediately.
